// File: rtl/bus_mem_responder_pkg.sv
// Shared definitions for the MERA-400 memory-module bus responder:
// FSM states, the idle bus word and the active-low inversion helper.
package bus_mem_responder_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DECODE,
      IGNORE,
      WAIT,
      RESP,
      RELEASE
   } state_t;

   localparam logic [15:0] BUS_IDLE_WORD = 16'hffff;

   // Same conversion the CPU bus drivers use between true and bus polarity.
   function automatic logic [15:0] bus_inv16(input logic [15:0] w);
      return ~w;
   endfunction

endpackage

// File: rtl/bus_mem_responder_if.sv
// MERA-400 system bus wires seen by a memory module; all signals active-low.
// Four-phase handshake: master pulls dr_ or dw_ low and holds it, slave answers
// rok_=0 (with rdt_ valid for reads), master releases the strobe, slave raises rok_.
interface bus_mem_responder_if;
   logic        dmcl_;
   logic        dw_;
   logic        dr_;
   logic [0:3]  dnb_;
   logic [0:15] dad_;
   logic [0:15] ddt_;
   logic        rok_;
   logic        rpe_;
   logic [0:15] rdt_;

   modport master (
      output dmcl_, dw_, dr_, dnb_, dad_, ddt_,
      input  rok_, rpe_, rdt_
   );

   modport slave (
      input  dmcl_, dw_, dr_, dnb_, dad_, ddt_,
      output rok_, rpe_, rdt_
   );
endinterface

// File: rtl/bus_mem_array.sv
// Single-port synchronous RAM, 16-bit words, one clock read latency.
module bus_mem_array #(
   parameter int ADDR_BITS = 12
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [15:0]          wdata,
   output logic [15:0]          rdata
);

   logic [15:0] mem_q [2**ADDR_BITS];
   logic [15:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
      rdata_q <= mem_q[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-module end of the MERA-400 system bus: answers dr_/dw_ cycles for
// one block of on-chip RAM and handshakes four-phase on rok_.
module bus_mem_responder
   import bus_mem_responder_pkg::*;
#(
   parameter logic [3:0] MODULE_NB   = 4'd0,
   parameter int         ADDR_BITS   = 12,
   parameter int         WAIT_CYCLES = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   bus_mem_responder_if.slave        bus,
   output logic                      proto_err,
   output state_t                    state_dbg
);

   logic                 rd_s_q, wr_s_q;
   logic [3:0]           nb_s_q;
   logic [15:0]          a_s_q, wd_s_q;
   state_t               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 is_rd_q, is_rd_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [15:0]          wdata_q, wdata_d;
   logic                 rok_q, rok_d;
   logic                 proto_err_q, proto_err_d;
   logic                 last, hit, own_req, other_req;
   logic                 mem_we;
   logic [ADDR_BITS-1:0] mem_addr;
   logic [15:0]          mem_wdata, mem_rdata;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      is_rd_d     = is_rd_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      proto_err_d = proto_err_q;
      last        = 1'b0;
      own_req     = is_rd_q ? rd_s_q : wr_s_q;
      other_req   = is_rd_q ? wr_s_q : rd_s_q;
      hit         = (nb_s_q == MODULE_NB) && ((a_s_q >> ADDR_BITS) == 16'd0);

      if ((state_q == DECODE || state_q == WAIT || state_q == RESP) && other_req) begin
         proto_err_d = 1'b1;
      end

      case (state_q)
         // Both strobes at once parks in IGNORE, which waits for both to rise.
         IDLE: begin
            if (rd_s_q && wr_s_q) begin
               proto_err_d = 1'b1;
               state_d     = IGNORE;
            end else if (rd_s_q || wr_s_q) begin
               is_rd_d = rd_s_q;
               state_d = DECODE;
            end
         end
         DECODE: begin
            if (!own_req) begin
               state_d = IDLE;
            end else if (hit) begin
               addr_d  = a_s_q[ADDR_BITS-1:0];
               wdata_d = wd_s_q;
               if (WAIT_CYCLES == 1) begin
                  last    = 1'b1;
                  state_d = RESP;
               end else begin
                  cnt_d   = 4'(WAIT_CYCLES - 1);
                  state_d = WAIT;
               end
            end else begin
               state_d = IGNORE;
            end
         end
         IGNORE: begin
            if (!rd_s_q && !wr_s_q) begin
               state_d = IDLE;
            end
         end
         // cnt_q holds the WAIT clocks still to go; DECODE counts as the first.
         WAIT: begin
            if (!own_req) begin
               state_d = IDLE;
            end else if (cnt_q == 4'd1) begin
               last    = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (!own_req) begin
               state_d = RELEASE;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      rok_d = (state_d != RESP);
   end

   // In DECODE the latched copies are not loaded yet, so the RAM sees the sampled bus.
   assign mem_addr  = (state_q == DECODE) ? a_s_q[ADDR_BITS-1:0] : addr_q;
   assign mem_wdata = (state_q == DECODE) ? wd_s_q : wdata_q;
   assign mem_we    = last && !is_rd_q && bus.dmcl_ && !rst;

   // dmcl_ acts directly so a master clear aborts even the last WAIT clock.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_s_q      <= 1'b0;
         wr_s_q      <= 1'b0;
         nb_s_q      <= 4'd0;
         a_s_q       <= 16'd0;
         wd_s_q      <= 16'd0;
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         is_rd_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= 16'd0;
         rok_q       <= 1'b1;
         proto_err_q <= 1'b0;
      end else begin
         rd_s_q  <= ~bus.dr_;
         wr_s_q  <= ~bus.dw_;
         nb_s_q  <= ~bus.dnb_;
         a_s_q   <= ~bus.dad_;
         wd_s_q  <= ~bus.ddt_;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         if (!bus.dmcl_) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            is_rd_q     <= 1'b0;
            rok_q       <= 1'b1;
            proto_err_q <= 1'b0;
         end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_rd_q     <= is_rd_d;
            rok_q       <= rok_d;
            proto_err_q <= proto_err_d;
         end
      end
   end

   bus_mem_array #(
      .ADDR_BITS (ADDR_BITS)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   assign bus.rok_  = rok_q;
   assign bus.rpe_  = 1'b1;
   assign bus.rdt_  = (state_q == RESP && is_rd_q) ? bus_inv16(mem_rdata) : BUS_IDLE_WORD;
   assign proto_err = proto_err_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder (MODULE_NB=0, ADDR_BITS=12, WAIT_CYCLES=2).
module tb_bus_mem_responder;
   import bus_mem_responder_pkg::*;

   typedef struct {
      bit          rd;
      logic [3:0]  nb;
      logic [15:0] addr;
      logic [15:0] wd;
      bit          exp_ok;
      logic [15:0] exp_rd;
   } vec_t;

   logic   clk;
   logic   rst;
   logic   proto_err;
   state_t state_dbg;
   int     n_vec;
   int     n_err;
   logic [15:0] exp_q[$];
   vec_t   vecs[16];

   bus_mem_responder_if bus();

   bus_mem_responder #(
      .MODULE_NB   (4'd0),
      .ADDR_BITS   (12),
      .WAIT_CYCLES (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .proto_err (proto_err),
      .state_dbg (state_dbg)
   );

   // clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string name, input string what,
                        input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s/%s: got %h expected %h", name, what, act, exp);
      end
   endtask

   task automatic release_strobes();
      bus.dr_ = 1'b1;
      bus.dw_ = 1'b1;
   endtask

   task automatic drive_req(input bit rd, input logic [3:0] nb,
                            input logic [15:0] addr, input logic [15:0] wd);
      bus.dnb_ = ~nb;
      bus.dad_ = ~addr;
      bus.ddt_ = ~wd;
      if (rd) bus.dr_ = 1'b0;
      else    bus.dw_ = 1'b0;
   endtask

   // Wait for rok_ low; returns the number of clocks taken, or limit if it never fell.
   task automatic wait_rok(input int limit, output int lat);
      lat = 0;
      while (bus.rok_ !== 1'b0 && lat < limit) begin
         tick();
         lat++;
      end
   endtask

   task automatic run_vec(input vec_t v, input string name);
      int lat;
      bit clean;
      logic [15:0] got;
      logic [15:0] inv;
      drive_req(v.rd, v.nb, v.addr, v.wd);
      if (v.exp_ok) begin
         if (v.rd) exp_q.push_back(v.exp_rd);
         wait_rok(12, lat);
         check(name, "latency", lat, 4);
         if (v.rd && exp_q.size() > 0) begin
            got = exp_q.pop_front();
            inv = ~got;
            check(name, "rdt", bus.rdt_, inv);
         end
         release_strobes();
         tick();
         check(name, "rok_hold", bus.rok_, 1'b0);
         tick();
         check(name, "rok_rel", {bus.rok_, bus.rpe_, bus.rdt_}, {2'b11, 16'hffff});
         tick();
         tick();
      end else begin
         clean = 1'b1;
         for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.rok_ !== 1'b1 || bus.rdt_ !== 16'hffff) clean = 1'b0;
         end
         check(name, "no_answer", clean, 1'b1);
         release_strobes();
         tick();
         tick();
      end
   endtask

   initial begin
      int lat;
      bit clean;
      vec_t v;

      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      bus.dmcl_ = 1'b1;
      bus.dr_   = 1'b1;
      bus.dw_   = 1'b1;
      bus.dnb_  = 4'hf;
      bus.dad_  = 16'hffff;
      bus.ddt_  = 16'hffff;

      vecs[0]  = '{1'b0, 4'd0, 16'h0010, 16'h1234, 1'b1, 16'h0000};
      vecs[1]  = '{1'b1, 4'd0, 16'h0010, 16'h0000, 1'b1, 16'h1234};
      vecs[2]  = '{1'b1, 4'd3, 16'h0010, 16'h0000, 1'b0, 16'h0000};
      vecs[3]  = '{1'b1, 4'd0, 16'h0010, 16'h0000, 1'b1, 16'h1234};
      vecs[4]  = '{1'b0, 4'd0, 16'h0fff, 16'h5a5a, 1'b1, 16'h0000};
      vecs[5]  = '{1'b1, 4'd0, 16'h1000, 16'h0000, 1'b0, 16'h0000};
      vecs[6]  = '{1'b1, 4'd0, 16'h0fff, 16'h0000, 1'b1, 16'h5a5a};
      vecs[7]  = '{1'b0, 4'd0, 16'h0000, 16'h7777, 1'b1, 16'h0000};
      vecs[8]  = '{1'b0, 4'd0, 16'h1000, 16'hdead, 1'b0, 16'h0000};
      vecs[9]  = '{1'b1, 4'd0, 16'h0000, 16'h0000, 1'b1, 16'h7777};
      vecs[10] = '{1'b0, 4'd0, 16'h0001, 16'hc3c3, 1'b1, 16'h0000};
      vecs[11] = '{1'b0, 4'd1, 16'h0001, 16'hbeef, 1'b0, 16'h0000};
      vecs[12] = '{1'b1, 4'd0, 16'h0001, 16'h0000, 1'b1, 16'hc3c3};
      vecs[13] = '{1'b0, 4'd0, 16'h0020, 16'h0000, 1'b1, 16'h0000};
      vecs[14] = '{1'b0, 4'd0, 16'h0030, 16'h0000, 1'b1, 16'h0000};
      vecs[15] = '{1'b1, 4'd0, 16'h0010, 16'h0000, 1'b1, 16'h1234};

      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("reset", "outputs", {bus.rok_, bus.rpe_, bus.rdt_, proto_err},
            {2'b11, 16'hffff, 1'b0});

      for (int i = 0; i < 16; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end
      check("table", "proto_err", proto_err, 1'b0);

      // abort: write released before rok_, RAM must keep its old value
      drive_req(1'b0, 4'd0, 16'h0020, 16'haaaa);
      tick();
      tick();
      release_strobes();
      clean = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.rok_ !== 1'b1) clean = 1'b0;
      end
      check("abort", "no_rok", clean, 1'b1);
      v = '{1'b1, 4'd0, 16'h0020, 16'h0000, 1'b1, 16'h0000};
      run_vec(v, "abort_rb");

      // reset while rok_ is low
      drive_req(1'b1, 4'd0, 16'h0010, 16'h0000);
      wait_rok(12, lat);
      check("rst_mid", "latency", lat, 4);
      rst = 1'b1;
      release_strobes();
      tick();
      check("rst_mid", "outputs", {bus.rok_, bus.rdt_}, {1'b1, 16'hffff});
      rst = 1'b0;
      tick();
      tick();

      // master clear during WAIT: no rok_, no write
      drive_req(1'b0, 4'd0, 16'h0030, 16'h1111);
      tick();
      tick();
      tick();
      bus.dmcl_ = 1'b0;
      clean = 1'b1;
      tick();
      if (bus.rok_ !== 1'b1) clean = 1'b0;
      release_strobes();
      tick();
      if (bus.rok_ !== 1'b1) clean = 1'b0;
      bus.dmcl_ = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.rok_ !== 1'b1) clean = 1'b0;
      end
      check("dmcl_wait", "no_rok", clean, 1'b1);
      v = '{1'b1, 4'd0, 16'h0030, 16'h0000, 1'b1, 16'h0000};
      run_vec(v, "dmcl_rb");

      // both strobes together
      bus.dnb_ = ~4'd0;
      bus.dad_ = ~16'h0010;
      bus.dr_  = 1'b0;
      bus.dw_  = 1'b0;
      clean = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.rok_ !== 1'b1) clean = 1'b0;
      end
      check("proto", "no_rok", clean, 1'b1);
      check("proto", "flag", proto_err, 1'b1);
      release_strobes();
      tick();
      tick();
      bus.dmcl_ = 1'b0;
      tick();
      bus.dmcl_ = 1'b1;
      tick();
      check("proto", "cleared", proto_err, 1'b0);

      // opposite strobe during a read response: flag set, read continues
      drive_req(1'b1, 4'd0, 16'h0010, 16'h0000);
      wait_rok(12, lat);
      check("mid_opp", "latency", lat, 4);
      bus.dw_ = 1'b0;
      tick();
      tick();
      check("mid_opp", "state", {proto_err, bus.rok_, bus.rdt_}, {2'b10, 16'hedcb});
      release_strobes();
      repeat (3) tick();
      check("mid_opp", "rok_rel", bus.rok_, 1'b1);
      bus.dmcl_ = 1'b0;
      tick();
      bus.dmcl_ = 1'b1;
      tick();
      check("mid_opp", "cleared", proto_err, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
